// File: rtl/mips_run_ctrl_if.sv
// Host-side load and register-dump streams of the MIPS run controller.
interface mips_run_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              dump_valid;
  logic              dump_ready;
  logic [4:0]        dump_idx;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output ld_valid, ld_data, ld_last, dump_ready,
    input  ld_ready, dump_valid, dump_idx, dump_data
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, dump_ready,
    output ld_ready, dump_valid, dump_idx, dump_data
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for one bring-up pass of the single-cycle MIPS core: load IM, run, dump RF.
// Optional macro RUN_CTRL_HALT_DETECT_EN ends RUN early on a self-branch (PC unchanged).
module mips_run_ctrl #(
  parameter int IMEM_AW = 8,
  parameter int DATA_W  = 32,
  parameter int RF_N    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        max_cycles,
  mips_run_ctrl_if.slave     host,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               cpu_rst_n,
  output logic               cpu_en,
  input  logic [DATA_W-1:0]  cpu_pc,
  output logic [4:0]         rf_rd_addr,
  input  logic [DATA_W-1:0]  rf_rd_data,
  output logic [DATA_W-1:0]  final_pc,
  output logic [31:0]        cycles_run,
  output logic               ld_overflow,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DUMP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [4:0] LAST_IDX = 5'(RF_N - 1);

  logic [2:0]       state;
  // One extra MSB: once set the address has reached IM depth and saturates there.
  logic [IMEM_AW:0] ld_addr;
  logic [31:0]      max_lat;
  logic [31:0]      cyc_cnt;
  logic [4:0]       idx;
  logic             ld_hs;
  logic             dump_hs;
  logic             halt_hit;
  logic             run_end;

`ifdef RUN_CTRL_HALT_DETECT_EN
  logic [DATA_W-1:0] prev_pc;
  logic              prev_vld;
  assign halt_hit = (state == S_RUN) && prev_vld && (cpu_pc == prev_pc);
`else
  assign halt_hit = 1'b0;
`endif

  assign ld_hs   = (state == S_LOAD) && host.ld_valid;
  assign dump_hs = (state == S_DUMP) && host.dump_ready;
  assign run_end = (state == S_RUN) && ((cyc_cnt == max_lat) || halt_hit);

  assign host.ld_ready   = (state == S_LOAD);
  assign imem_we         = ld_hs && !ld_addr[IMEM_AW];
  assign imem_addr       = ld_addr[IMEM_AW-1:0];
  assign imem_wdata      = (state == S_LOAD) ? host.ld_data : '0;

  assign cpu_rst_n = (state == S_RUN) || (state == S_DUMP) || (state == S_DONE);
  assign cpu_en    = (state == S_RUN) && (cyc_cnt != max_lat) && !halt_hit;

  assign host.dump_valid = (state == S_DUMP);
  assign host.dump_idx   = idx;
  assign host.dump_data  = (state == S_DUMP) ? rf_rd_data : '0;
  assign rf_rd_addr      = idx;

  assign busy = (state == S_LOAD) || (state == S_RUN) || (state == S_DUMP);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ld_addr     <= '0;
      max_lat     <= '0;
      cyc_cnt     <= '0;
      idx         <= '0;
      final_pc    <= '0;
      cycles_run  <= '0;
      ld_overflow <= 1'b0;
`ifdef RUN_CTRL_HALT_DETECT_EN
      prev_pc     <= '0;
      prev_vld    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD;
            max_lat     <= max_cycles;
            ld_addr     <= '0;
            cyc_cnt     <= '0;
            idx         <= '0;
            final_pc    <= '0;
            cycles_run  <= '0;
            ld_overflow <= 1'b0;
`ifdef RUN_CTRL_HALT_DETECT_EN
            prev_vld    <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (ld_hs) begin
            if (ld_addr[IMEM_AW]) ld_overflow <= 1'b1;
            else                  ld_addr     <= ld_addr + 1'b1;
            if (host.ld_last) state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cpu_en) begin
            cyc_cnt <= cyc_cnt + 1'b1;
`ifdef RUN_CTRL_HALT_DETECT_EN
            prev_pc  <= cpu_pc;
            prev_vld <= 1'b1;
`endif
          end
          if (run_end) begin
            state      <= S_DUMP;
            // A zero-cycle run never executed, so report PC 0 rather than the reset PC.
            final_pc   <= (cyc_cnt == '0) ? '0 : cpu_pc;
            cycles_run <= cyc_cnt;
            idx        <= '0;
          end
        end
        S_DUMP: begin
          if (dump_hs) begin
            if (idx == LAST_IDX) state <= S_DONE;
            else                 idx   <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: table of load/run passes plus halt, overflow and reset sequences.
module tb_mips_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] max_cycles;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        dump_ready;
  logic        halt_mode;
  logic [31:0] core_pc;

  always #5 clk = ~clk;

  mips_run_ctrl_if #(.DATA_W(32)) hb ();
  mips_run_ctrl_if #(.DATA_W(32)) hs ();

  assign hb.ld_valid = ld_valid;  assign hs.ld_valid = ld_valid;
  assign hb.ld_data = ld_data;    assign hs.ld_data = ld_data;
  assign hb.ld_last = ld_last;    assign hs.ld_last = ld_last;
  assign hb.dump_ready = dump_ready;  assign hs.dump_ready = dump_ready;

  // Default-size DUT
  logic        b_imem_we, b_cpu_rst_n, b_cpu_en, b_ld_overflow, b_busy, b_done;
  logic [7:0]  b_imem_addr;
  logic [31:0] b_imem_wdata, b_rf_rd_data, b_final_pc, b_cycles_run;
  logic [4:0]  b_rf_rd_addr;
  // Four-word IM DUT, driven in lockstep
  logic        s_imem_we, s_cpu_rst_n, s_cpu_en, s_ld_overflow, s_busy, s_done;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata, s_rf_rd_data, s_final_pc, s_cycles_run;
  logic [4:0]  s_rf_rd_addr;

  assign b_rf_rd_data = 32'h1000_0000 + {27'd0, b_rf_rd_addr} * 32'd17;
  assign s_rf_rd_data = 32'h1000_0000 + {27'd0, s_rf_rd_addr} * 32'd17;

  mips_run_ctrl #(.IMEM_AW(8), .DATA_W(32), .RF_N(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cycles(max_cycles), .host(hb.slave),
    .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .cpu_rst_n(b_cpu_rst_n), .cpu_en(b_cpu_en), .cpu_pc(core_pc),
    .rf_rd_addr(b_rf_rd_addr), .rf_rd_data(b_rf_rd_data),
    .final_pc(b_final_pc), .cycles_run(b_cycles_run), .ld_overflow(b_ld_overflow),
    .busy(b_busy), .done(b_done)
  );

  mips_run_ctrl #(.IMEM_AW(2), .DATA_W(32), .RF_N(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .max_cycles(max_cycles), .host(hs.slave),
    .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .cpu_rst_n(s_cpu_rst_n), .cpu_en(s_cpu_en), .cpu_pc(core_pc),
    .rf_rd_addr(s_rf_rd_addr), .rf_rd_data(s_rf_rd_data),
    .final_pc(s_final_pc), .cycles_run(s_cycles_run), .ld_overflow(s_ld_overflow),
    .busy(s_busy), .done(s_done)
  );

  // Core stand-in: PC steps by 4 per enabled cycle; in halt mode it sticks at 0x0C.
  always @(posedge clk) begin
    if (!b_cpu_rst_n) core_pc <= 32'd0;
    else if (b_cpu_en && !(halt_mode && core_pc == 32'hC)) core_pc <= core_pc + 32'd4;
  end

  int          en_cnt = 0;
  logic [7:0]  b_log_addr[$];
  logic [31:0] b_log_data[$];
  logic [1:0]  s_log_addr[$];
  logic [31:0] s_log_data[$];

  always @(posedge clk) begin
    if (b_cpu_en) en_cnt++;
    if (b_imem_we) begin b_log_addr.push_back(b_imem_addr); b_log_data.push_back(b_imem_wdata); end
    if (s_imem_we) begin s_log_addr.push_back(s_imem_addr); s_log_data.push_back(s_imem_wdata); end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input int nw, input logic [31:0] maxc, input logic [31:0] exp_cyc,
                          input logic [31:0] exp_pc, input bit stall);
    int en0, bl0, sl0, sexp, t, k;
    int exp_idx;
    logic [3:0] pat;
    pat = 4'b1001;
    en0 = en_cnt;
    bl0 = b_log_addr.size();
    sl0 = s_log_addr.size();
    max_cycles = maxc;
    start = 1'b1;
    tick();
    start = 1'b0;
    max_cycles = 32'hFFFF_FFFF;
    check("load_entry", {28'd0, b_busy, hb.ld_ready, b_cpu_rst_n, s_ld_overflow}, 32'b1100);
    for (int i = 0; i < nw; i++) begin
      if (i == 1) begin ld_valid = 1'b0; tick(); end
      ld_valid = 1'b1;
      ld_data  = 32'hA000_0000 + i;
      ld_last  = (i == nw - 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    t = 0;
    while (!hb.dump_valid && t < int'(maxc) + 50) begin tick(); t++; end
    check("run_timeout", {31'd0, hb.dump_valid}, 32'd1);
    check("en_cycles", en_cnt - en0, exp_cyc);
    check("cycles_run", b_cycles_run, exp_cyc);
    check("final_pc", b_final_pc, exp_pc);
    check("b_writes", b_log_addr.size() - bl0, nw);
    for (int j = 0; j < nw && bl0 + j < b_log_addr.size(); j++) begin
      check("b_waddr", {24'd0, b_log_addr[bl0+j]}, j);
      check("b_wdata", b_log_data[bl0+j], 32'hA000_0000 + j);
    end
    sexp = (nw < 4) ? nw : 4;
    check("s_writes", s_log_addr.size() - sl0, sexp);
    for (int j = 0; j < sexp && sl0 + j < s_log_addr.size(); j++)
      check("s_waddr", {30'd0, s_log_addr[sl0+j]}, j);
    check("s_overflow_run", {31'd0, s_ld_overflow}, (nw > 4) ? 32'd1 : 32'd0);
    check("b_overflow", {31'd0, b_ld_overflow}, 32'd0);
    exp_idx = 0;
    k = 0;
    t = 0;
    while (exp_idx < 32 && t < 400) begin
      check("dump_idx", {27'd0, hb.dump_idx}, exp_idx);
      check("dump_data", hb.dump_data, 32'h1000_0000 + exp_idx * 17);
      dump_ready = stall ? pat[k % 4] : 1'b1;
      tick();
      if (dump_ready) exp_idx++;
      k++;
      t++;
    end
    dump_ready = 1'b0;
    check("done_state", {27'd0, b_done, b_busy, b_cpu_en, b_cpu_rst_n, hb.dump_valid}, 32'b10010);
    check("s_done", {31'd0, s_done}, 32'd1);
    tick(); tick(); tick();
    check("final_pc_hold", b_final_pc, exp_pc);
    check("s_overflow_done", {31'd0, s_ld_overflow}, (nw > 4) ? 32'd1 : 32'd0);
  endtask

  typedef struct {
    int          nw;
    logic [31:0] maxc;
    logic [31:0] exp_cyc;
    logic [31:0] exp_pc;
    bit          stall;
  } vec_t;

  vec_t vecs[4];
  logic [31:0] halt_cyc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 32'd10, 32'd10, 32'h28, 1'b1};
    vecs[1] = '{6, 32'd3,  32'd3,  32'h0C, 1'b0};
    vecs[2] = '{1, 32'd0,  32'd0,  32'h00, 1'b0};
    vecs[3] = '{2, 32'd1,  32'd1,  32'h04, 1'b1};
`ifdef RUN_CTRL_HALT_DETECT_EN
    halt_cyc = 32'd4;
`else
    halt_cyc = 32'd1000;
`endif
    rst_n = 1'b0; start = 1'b0; max_cycles = '0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; dump_ready = 1'b0; halt_mode = 1'b0;
    tick(); tick();
    check("rst_ctrl", {26'd0, b_busy, b_done, b_cpu_rst_n, b_cpu_en, hb.ld_ready, hb.dump_valid}, 32'd0);
    check("rst_regs", b_final_pc | b_cycles_run | {31'd0, b_ld_overflow} | {24'd0, b_imem_addr}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_hold", {30'd0, b_busy, b_done}, 32'd0);

    for (int v = 0; v < 4; v++)
      run_pass(vecs[v].nw, vecs[v].maxc, vecs[v].exp_cyc, vecs[v].exp_pc, vecs[v].stall);

    halt_mode = 1'b1;
    run_pass(3, 32'd1000, halt_cyc, 32'h0C, 1'b0);
    halt_mode = 1'b0;

    // Reset in the middle of RUN
    max_cycles = 32'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'h1234_5678;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tick(); tick(); tick();
    check("mid_run_en", {31'd0, b_cpu_en}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_ctrl", {28'd0, b_busy, b_done, b_cpu_rst_n, b_cpu_en}, 32'd0);
    check("mid_rst_cycles", b_cycles_run, 32'd0);
    tick();
    check("mid_rst_idle", {30'd0, b_busy, b_done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
